avmm_cmd_master: RTL and testbench
==================================

# avmm_cmd_master

Command-to-Avalon-MM master that sits directly upstream of the debug monitor's MM bridge slave: 24-bit address, 32-bit data, burstcount 1. It accepts single read/write commands on a valid/ready stream from the JTAG debug command decoder. It issues each as one Avalon-MM transaction, honouring waitrequest and readdatavalid, and returns one response per command. A timeout guarantees the debug path never hangs on an unresponsive slave.

## Interface
Parameters:
- ADDR_W, 24, Avalon address width (matches bridge slave)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT, 1024, max cycles from command issue to completion before error (≥4)

Ports:
- clk_clk  in  1  single clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_address  in  ADDR_W  target address
- cmd_writedata  in  DATA_W  write data
- cmd_byteenable  in  DATA_W/8  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_write  out  1  echo of cmd_write
- rsp_timeout  out  1  transaction timed out
- rsp_readdata  out  DATA_W  read data; 0 for writes and timeouts
- avm_address  out  ADDR_W
- avm_writedata  out  DATA_W
- avm_byteenable  out  DATA_W/8
- avm_burstcount  out  1  constant 1
- avm_read  out  1
- avm_write  out  1
- avm_debugaccess  out  1  constant 0
- avm_waitrequest  in  1
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1

## Operation
- States: IDLE, ISSUE, RDWAIT, RSP.
- IDLE: cmd_ready=1. On handshake, register address/data/byteenable/write, clear timer, go to ISSUE.
- ISSUE: drive avm_read or avm_write with registered fields, held stable.
  - waitrequest=0 while write is asserted: write accepted; go to RSP, rsp_timeout=0.
  - waitrequest=0 while read is asserted: go to RDWAIT.
- RDWAIT: avm_read=0. On readdatavalid, capture avm_readdata, go to RSP.
- RSP: rsp_valid=1, fields stable; on rsp_ready go to IDLE.
- Timer: counts every cycle in ISSUE and RDWAIT.
  - Reaching TIMEOUT-1 forces RSP with rsp_timeout=1 and rsp_readdata=0.
  - In ISSUE this deasserts read/write. This is a deliberate Avalon violation, accepted for the debug path.
- Stale read: a timeout from RDWAIT sets a stale flag. The next readdatavalid in any state is dropped and clears the flag. If the flag is set while in RDWAIT, the first readdatavalid is treated as stale.
- readdatavalid outside RDWAIT with the stale flag clear: ignored.
- One transaction outstanding at most. cmd_ready=0 in every state except IDLE.
- Reset, including mid-transaction: state IDLE, stale flag clear, timer 0.
  - All outputs 0 except cmd_ready=1 and avm_burstcount=1.
  - No response is produced for an aborted command.
- Timer width: $clog2(TIMEOUT+1). The counter saturates; it never wraps.

## Timing
- All outputs are registered except cmd_ready, which is decoded from state.
- Cycle 0: cmd handshake. Cycle 1: avm_read/avm_write asserted.
- Write, no wait: accepted in cycle 1, rsp_valid in cycle 2. Each waitrequest cycle adds one.
- Read, no wait, readdatavalid one cycle after accept: accept in cycle 1, readdatavalid in cycle 2, rsp_valid in cycle 3.
- RSP → IDLE on the rsp_ready cycle; the next cmd handshake is possible the following cycle.
- Best-case throughput: write every 3 cycles, read every 4.
- Timeout: rsp_valid exactly TIMEOUT cycles after the cmd handshake cycle.

## Structure
- Shared package avmm_dbg_pkg holds:
  - the state enum
  - default widths ADDR_W/DATA_W
  - the response-field struct {write, timeout, readdata}, shared with the JTAG command decoder
- No sub-module; the FSM, timer and capture registers are a single module.

## Test plan
- Write 0x00_1234 data 0xCAFEF00D byteenable 0xF, waitrequest 0 → single avm_write pulse in cycle 1 with those fields; rsp_valid in cycle 2 with write=1, timeout=0, readdata=0.
- Read 0xFFFFFC, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with 0xA5A55A5A → avm_read held 4 cycles with stable address; rsp_readdata=0xA5A55A5A, timeout=0.
- TIMEOUT=16, read with waitrequest stuck high → rsp_valid 16 cycles after handshake with timeout=1, readdata=0, avm_read deasserted.
- TIMEOUT=16, read accepted but readdatavalid arrives at cycle 20 with 0x11111111, then a new read returns 0x22222222 → first response is timeout; the late beat is dropped; the second response has readdata=0x22222222.
- rsp_ready held low 10 cycles with cmd_valid high → cmd_ready=0 and no new avm_* activity; the response stays stable; the next command is issued after the handshake.
- reset_reset asserted one cycle during RDWAIT → next cycle all avm_* strobes 0, rsp_valid 0, cmd_ready 1; a subsequent write completes normally.

Source files
------------

// File: rtl/avmm_dbg_pkg.sv
// Shared definitions for the debug-path Avalon-MM command master and the
// JTAG command decoder that feeds it.
//   - dbg_state_e : command master FSM states
//   - DBG_ADDR_W / DBG_DATA_W : default bus widths (bridge slave geometry)
//   - dbg_rsp_t   : response fields returned per command
package avmm_dbg_pkg;

    localparam int DBG_ADDR_W = 24;
    localparam int DBG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDWAIT,
        ST_RSP
    } dbg_state_e;

    typedef struct packed {
        logic                  write;
        logic                  timeout;
        logic [DBG_DATA_W-1:0] readdata;
    } dbg_rsp_t;

endpackage

// File: rtl/avmm_cmd_master.sv
// Single-outstanding command to Avalon-MM master for the debug path.
// Accepts one read/write command on a valid/ready stream, runs it as a
// single burstcount-1 Avalon-MM transaction and returns one response.
// A cycle timer bounds every transaction so the debug path cannot hang.
//
// Ports
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   cmd_*                     : command stream in (valid/ready)
//   rsp_*                     : response stream out (valid/ready)
//   avm_*                     : Avalon-MM master interface
module avmm_cmd_master
    import avmm_dbg_pkg::*;
#(
    parameter int ADDR_W  = DBG_ADDR_W,
    parameter int DATA_W  = DBG_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [DATA_W-1:0]   cmd_writedata,
    input  logic [DATA_W/8-1:0] cmd_byteenable,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic                rsp_timeout,
    output logic [DATA_W-1:0]   rsp_readdata,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_burstcount,
    output logic                avm_read,
    output logic                avm_write,
    output logic                avm_debugaccess,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam int BE_W  = DATA_W / 8;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    dbg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              write_q, write_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  timer_inc;
    logic              stale_q, stale_d;
    logic              expire;

    // Saturating increment; the timer never wraps.
    assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
    // Expiry is judged on the incremented value so that the response lands
    // exactly TIMEOUT cycles after the command handshake.
    assign expire    = (timer_inc == TMR_LAST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        write_d       = write_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        timer_d       = timer_q;
        stale_d       = stale_q;

        // A late beat from a timed-out read is swallowed wherever it arrives.
        if (avm_readdatavalid && stale_q) stale_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    be_d    = cmd_byteenable;
                    write_d = cmd_write;
                    rd_d    = !cmd_write;
                    wr_d    = cmd_write;
                    timer_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_inc;
                // A real acceptance wins over a coincident expiry.
                if (!avm_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (write_q) begin
                        rsp_valid_d   = 1'b1;
                        rsp_write_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                        state_d       = ST_RSP;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (expire) begin
                    // Dropping the strobe under waitrequest breaks Avalon
                    // rules; tolerated so the debug path always recovers.
                    rd_d          = 1'b0;
                    wr_d          = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = write_q;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = ST_RSP;
                end
            end
            ST_RDWAIT: begin
                timer_d = timer_inc;
                if (avm_readdatavalid && !stale_q) begin
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = avm_readdata;
                    state_d       = ST_RSP;
                end else if (expire) begin
                    // The read is still owed by the slave; drop its beat later.
                    stale_d       = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            write_q       <= 1'b0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            timer_q       <= '0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            write_q       <= write_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            timer_q       <= timer_d;
            stale_q       <= stale_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign rsp_readdata    = rsp_rdata_q;
    assign avm_address     = addr_q;
    assign avm_writedata   = wdata_q;
    assign avm_byteenable  = be_q;
    assign avm_burstcount  = 1'b1;
    assign avm_read        = rd_q;
    assign avm_write       = wr_q;
    assign avm_debugaccess = 1'b0;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master (TIMEOUT=16). Inputs are driven and
// outputs sampled on the falling edge; expected responses are queued when a
// command is issued and popped when the DUT presents a response.
module tb_avmm_cmd_master;
    import avmm_dbg_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [23:0] cmd_address;
    logic [31:0] cmd_writedata;
    logic [3:0]  cmd_byteenable;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_readdata;
    logic [23:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_burstcount, avm_read, avm_write, avm_debugaccess;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;

    int checks   = 0;
    int failures = 0;
    dbg_rsp_t sb[$];

    avmm_cmd_master #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
        .cmd_byteenable(cmd_byteenable),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_timeout(rsp_timeout), .rsp_readdata(rsp_readdata),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_read(avm_read), .avm_write(avm_write),
        .avm_debugaccess(avm_debugaccess), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic to, input logic [31:0] rd);
        dbg_rsp_t e;
        e.write = w; e.timeout = to; e.readdata = rd;
        sb.push_back(e);
    endtask

    // Drive a command at the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic w, input logic [23:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        chk("issue.cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a;
        cmd_writedata = d; cmd_byteenable = be;
        tick();
        cmd_valid = 1'b0;
        chk("issue.cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input int start, input int budget,
                            output int cyc);
        cyc = start;
        while (rsp_valid !== 1'b1 && cyc < start + budget) begin
            tick();
            cyc++;
        end
        chk({tag, ".rsp_in_budget"}, rsp_valid, 1);
    endtask

    // Compare the presented response with the scoreboard head, then consume it.
    task automatic take_rsp(input string tag);
        dbg_rsp_t e;
        chk({tag, ".rsp_valid"}, rsp_valid, 1);
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s.sb_empty observed=response expected=none", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".rsp_write"}, rsp_write, e.write);
            chk({tag, ".rsp_timeout"}, rsp_timeout, e.timeout);
            chk({tag, ".rsp_readdata"}, rsp_readdata, e.readdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".rsp_done"}, rsp_valid, 0);
    endtask

    initial begin
        int c;
        reset_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = '0; cmd_writedata = '0; cmd_byteenable = '0;
        rsp_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        tick(); tick();
        chk("rst.cmd_ready", cmd_ready, 1);
        chk("rst.avm_read", avm_read, 0);
        chk("rst.avm_write", avm_write, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.burstcount", avm_burstcount, 1);
        chk("rst.debugaccess", avm_debugaccess, 0);
        chk("rst.avm_address", avm_address, 0);
        reset_reset = 1'b0;
        tick();

        // Write, no wait: strobe in cycle 1, response in cycle 2.
        push(1'b1, 1'b0, 32'h0);
        issue(1'b1, 24'h001234, 32'hCAFEF00D, 4'hF);
        chk("wr.avm_write", avm_write, 1);
        chk("wr.avm_read", avm_read, 0);
        chk("wr.avm_address", avm_address, 24'h001234);
        chk("wr.avm_writedata", avm_writedata, 32'hCAFEF00D);
        chk("wr.avm_byteenable", avm_byteenable, 4'hF);
        tick();
        chk("wr.pulse_end", avm_write, 0);
        take_rsp("wr");

        // Read with three waitrequest cycles, data two cycles after accept.
        push(1'b0, 1'b0, 32'hA5A55A5A);
        avm_waitrequest = 1'b1;
        issue(1'b0, 24'hFFFFFC, 32'h0, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            chk("rd.avm_read_held", avm_read, 1);
            chk("rd.avm_address", avm_address, 24'hFFFFFC);
            if (k == 4) avm_waitrequest = 1'b0;
            tick();
        end
        chk("rd.avm_read_drop", avm_read, 0);
        chk("rd.no_rsp_yet", rsp_valid, 0);
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'hA5A55A5A;
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        take_rsp("rd");

        // Timeout in ISSUE: waitrequest stuck high.
        push(1'b0, 1'b1, 32'h0);
        avm_waitrequest = 1'b1;
        issue(1'b0, 24'h000010, 32'h0, 4'hF);
        wait_rsp("to_issue", 1, 30, c);
        chk("to_issue.latency", c, 16);
        chk("to_issue.avm_read", avm_read, 0);
        avm_waitrequest = 1'b0;
        take_rsp("to_issue");

        // Timeout in RDWAIT; late beat arrives while the next read waits.
        push(1'b0, 1'b1, 32'h0);
        issue(1'b0, 24'h000020, 32'h0, 4'hF);
        wait_rsp("to_rdwait", 1, 30, c);
        chk("to_rdwait.latency", c, 16);
        take_rsp("to_rdwait");
        push(1'b0, 1'b0, 32'h22222222);
        issue(1'b0, 24'h000100, 32'h0, 4'hF);
        tick();
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h11111111;
        tick();
        chk("stale.dropped", rsp_valid, 0);
        avm_readdata = 32'h22222222;
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        take_rsp("stale.next");

        // Response back-pressure with a command waiting.
        push(1'b1, 1'b0, 32'h0);
        issue(1'b1, 24'h00FF00, 32'h0BADBEEF, 4'h5);
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 24'h000ABC;
        cmd_byteenable = 4'hF;
        for (int k = 0; k < 10; k++) begin
            chk("bp.cmd_ready", cmd_ready, 0);
            chk("bp.avm_strobes", {avm_read, avm_write}, 2'b00);
            chk("bp.rsp_stable", {rsp_valid, rsp_write, rsp_timeout}, 3'b110);
            tick();
        end
        take_rsp("bp");
        push(1'b0, 1'b0, 32'h5EED1234);
        chk("bp.next_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("bp.next_avm_read", avm_read, 1);
        chk("bp.next_address", avm_address, 24'h000ABC);
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'h5EED1234;
        tick();
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        take_rsp("bp.next");

        // Reset during RDWAIT aborts silently.
        issue(1'b0, 24'h000300, 32'h0, 4'hF);
        tick();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        chk("mrst.avm_strobes", {avm_read, avm_write}, 2'b00);
        chk("mrst.rsp_valid", rsp_valid, 0);
        chk("mrst.cmd_ready", cmd_ready, 1);
        push(1'b1, 1'b0, 32'h0);
        issue(1'b1, 24'h000042, 32'h00000001, 4'h3);
        chk("mrst.wr_strobe", avm_write, 1);
        chk("mrst.wr_be", avm_byteenable, 4'h3);
        tick();
        take_rsp("mrst.wr");
        chk("end.sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
